fifo_level_bcd: RTL and testbench

Sequential binary-to-BCD converter that turns a binary FIFO occupancy or data value into decimal digit codes for the 7-segment display stage.
- Conversion is iterative double-dabble (add-3 and shift), one bit per clock.
- Results are registered and held until the next conversion completes.
- Each output digit drives one segment-decoder instance directly.
- Leading zeros are optionally replaced by code 4'hF, which the decoder renders as all segments dark.

---
 rtl/fifo_level_bcd.sv | 138 +++++++++++++
 tb/tb_fifo_level_bcd.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_level_bcd.sv
// Sequential double-dabble binary-to-BCD converter feeding the 7-segment display stage.
// One bit per clock; results are held until the next conversion completes.
module fifo_level_bcd #(
    parameter int WIDTH         = 8,
    parameter int DIGITS        = 3,
    parameter int BLANK_LEADING = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [4*DIGITS-1:0]   digits
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    function automatic logic [BW-1:0] resetDigits();
        logic [BW-1:0] r;
        r = '0;
        for (int i = 1; i < DIGITS; i++) begin
            if (BLANK_LEADING != 0) r[4*i +: 4] = 4'hF;
        end
        return r;
    endfunction

    localparam logic [BW-1:0] RESET_DIGITS = resetDigits();

    logic [1:0]        state_q,  state_d;
    logic [WIDTH-1:0]  shift_q,  shift_d;
    logic [BW-1:0]     bcd_q,    bcd_d;
    logic              sticky_q, sticky_d;
    logic [CW-1:0]     cnt_q,    cnt_d;
    logic [BW-1:0]     digits_q, digits_d;
    logic              ovf_q,    ovf_d;
    logic              done_q,   done_d;

    logic [BW-1:0]         adjusted;
    logic [BW+WIDTH:0]     shifted;
    logic [BW-1:0]         formatted;
    logic                  leading;

    // Add-3 correction on every digit, then shift {scratch, shiftreg} left; the top bit is the overflow carry.
    always_comb begin
        adjusted = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) adjusted[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        shifted = {adjusted, shift_q, 1'b0};
    end

    always_comb begin
        formatted = bcd_q;
        leading   = 1'b1;
        if (sticky_q) begin
            formatted = {DIGITS{4'h9}};
        end else if (BLANK_LEADING != 0) begin
            for (int i = DIGITS - 1; i >= 1; i--) begin
                if (leading && (bcd_q[4*i +: 4] == 4'h0)) begin
                    formatted[4*i +: 4] = 4'hF;
                end else begin
                    leading = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bcd_d    = bcd_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        digits_d = digits_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d  = value;
                    bcd_d    = '0;
                    sticky_d = 1'b0;
                    cnt_d    = CW'(WIDTH);
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d    = shifted[BW+WIDTH-1:WIDTH];
                shift_d  = shifted[WIDTH-1:0];
                sticky_d = sticky_q | shifted[BW+WIDTH];
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = DONE;
            end
            DONE: begin
                digits_d = formatted;
                ovf_d    = sticky_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bcd_q    <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            digits_q <= RESET_DIGITS;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bcd_q    <= bcd_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign ovf    = ovf_q;
    assign digits = digits_q;

endmodule

// File: tb/tb_fifo_level_bcd.sv
// Randomised bench for fifo_level_bcd: three instances cover default, unblanked and 10-bit configurations.
// Expected digits come from decimal arithmetic on the input value.
module tb_fifo_level_bcd;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  startV;
    logic [7:0]  value0;
    logic [7:0]  value1;
    logic [9:0]  value2;
    logic [2:0]  busyV;
    logic [2:0]  doneV;
    logic [2:0]  ovfV;
    logic [11:0] digitsV [3];

    int passCnt  = 0;
    int totalCnt = 0;

    always #5 clk = ~clk;

    fifo_level_bcd #(.WIDTH(8), .DIGITS(3), .BLANK_LEADING(1)) dut (
        .clk(clk), .reset(reset), .start(startV[0]), .value(value0),
        .busy(busyV[0]), .done(doneV[0]), .ovf(ovfV[0]), .digits(digitsV[0])
    );

    fifo_level_bcd #(.WIDTH(8), .DIGITS(3), .BLANK_LEADING(0)) dutNoBlank (
        .clk(clk), .reset(reset), .start(startV[1]), .value(value1),
        .busy(busyV[1]), .done(doneV[1]), .ovf(ovfV[1]), .digits(digitsV[1])
    );

    fifo_level_bcd #(.WIDTH(10), .DIGITS(3), .BLANK_LEADING(1)) dutWide (
        .clk(clk), .reset(reset), .start(startV[2]), .value(value2),
        .busy(busyV[2]), .done(doneV[2]), .ovf(ovfV[2]), .digits(digitsV[2])
    );

    // Decimal reference: saturate to 999 on overflow, otherwise split by powers of ten and blank leading zeros.
    function automatic logic [11:0] refDigits(input int v, input bit blank);
        logic [11:0] r;
        bit lead;
        if (v > 999) return 12'h999;
        r = {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
        if (blank) begin
            lead = 1'b1;
            for (int i = 2; i >= 1; i--) begin
                if (lead && r[4*i +: 4] == 4'h0) r[4*i +: 4] = 4'hF;
                else lead = 1'b0;
            end
        end
        return r;
    endfunction

    task automatic setValue(input int k, input int v);
        case (k)
            0:       value0 = v[7:0];
            1:       value1 = v[7:0];
            default: value2 = v[9:0];
        endcase
    endtask

    task automatic startConv(input int k, input int v);
        setValue(k, v);
        startV[k] = 1'b1;
        @(posedge clk); #1;
        startV[k] = 1'b0;
        setValue(k, int'($urandom));
    endtask

    task automatic waitDone(input int k, output int lat, output int busyCnt,
                            output logic [11:0] dg, output logic ov);
        lat     = 0;
        busyCnt = 0;
        while (doneV[k] !== 1'b1 && lat < 40) begin
            if (busyV[k] === 1'b1) busyCnt++;
            @(posedge clk); #1;
            lat++;
        end
        dg = digitsV[k];
        ov = ovfV[k];
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        startV = 3'b000;
        value0 = '0;
        value1 = '0;
        value2 = '0;
        repeat (2) @(posedge clk);
        #1;
        totalCnt++; if (busyV !== 3'b000) $display("[TB] FAIL reset_busy: got %b expected 000", busyV); else passCnt++;
        totalCnt++; if (doneV !== 3'b000) $display("[TB] FAIL reset_done: got %b expected 000", doneV); else passCnt++;
        totalCnt++; if (ovfV !== 3'b000) $display("[TB] FAIL reset_ovf: got %b expected 000", ovfV); else passCnt++;
        totalCnt++; if (digitsV[0] !== 12'hFF0) $display("[TB] FAIL reset_digits_blank: got %h expected ff0", digitsV[0]); else passCnt++;
        totalCnt++; if (digitsV[1] !== 12'h000) $display("[TB] FAIL reset_digits_noblank: got %h expected 000", digitsV[1]); else passCnt++;
        totalCnt++; if (digitsV[2] !== 12'hFF0) $display("[TB] FAIL reset_digits_wide: got %h expected ff0", digitsV[2]); else passCnt++;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_zero();
        int lat, bc;
        logic [11:0] dg;
        logic ov;
        startConv(0, 0);
        waitDone(0, lat, bc, dg, ov);
        totalCnt++; if (lat !== 9) $display("[TB] FAIL zero_latency: got %0d expected 9", lat); else passCnt++;
        totalCnt++; if (bc !== 9) $display("[TB] FAIL zero_busy_cycles: got %0d expected 9", bc); else passCnt++;
        totalCnt++; if (dg !== refDigits(0, 1'b1)) $display("[TB] FAIL zero_digits: got %h expected %h", dg, refDigits(0, 1'b1)); else passCnt++;
        totalCnt++; if (ov !== 1'b0) $display("[TB] FAIL zero_ovf: got %b expected 0", ov); else passCnt++;
        @(posedge clk); #1;
        totalCnt++; if (doneV[0] !== 1'b0) $display("[TB] FAIL done_one_cycle: got %b expected 0", doneV[0]); else passCnt++;
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, bc;
        logic [11:0] d1, d2;
        logic ov;
        startConv(0, 42);
        waitDone(0, lat1, bc, d1, ov);
        startConv(0, 100);
        totalCnt++; if (busyV[0] !== 1'b1) $display("[TB] FAIL b2b_no_gap: got busy %b expected 1", busyV[0]); else passCnt++;
        waitDone(0, lat2, bc, d2, ov);
        totalCnt++; if (d1 !== refDigits(42, 1'b1)) $display("[TB] FAIL b2b_first: got %h expected %h", d1, refDigits(42, 1'b1)); else passCnt++;
        totalCnt++; if (d2 !== refDigits(100, 1'b1)) $display("[TB] FAIL b2b_second: got %h expected %h", d2, refDigits(100, 1'b1)); else passCnt++;
        totalCnt++; if (lat2 !== 9) $display("[TB] FAIL b2b_latency: got %0d expected 9", lat2); else passCnt++;
    endtask

    task automatic test_ignore_busy();
        int cyc, lat, bc;
        logic [11:0] dg;
        logic ov;
        startConv(0, 255);
        cyc = 1;
        while (doneV[0] !== 1'b1 && cyc < 40) begin
            if (cyc >= 2 && cyc <= 6) begin
                startV[0] = 1'b1;
                value0    = 8'd7;
            end else begin
                startV[0] = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        startV[0] = 1'b0;
        totalCnt++; if (cyc !== 10) $display("[TB] FAIL ignore_latency: got %0d expected 10", cyc); else passCnt++;
        totalCnt++; if (digitsV[0] !== refDigits(255, 1'b1)) $display("[TB] FAIL ignore_digits: got %h expected %h", digitsV[0], refDigits(255, 1'b1)); else passCnt++;
        @(posedge clk); #1;
        totalCnt++; if (busyV[0] !== 1'b0) $display("[TB] FAIL ignore_no_queue: got busy %b expected 0", busyV[0]); else passCnt++;
        startConv(0, 7);
        totalCnt++; if (digitsV[0] !== refDigits(255, 1'b1)) $display("[TB] FAIL hold_during_busy: got %h expected %h", digitsV[0], refDigits(255, 1'b1)); else passCnt++;
        waitDone(0, lat, bc, dg, ov);
        totalCnt++; if (dg !== refDigits(7, 1'b1)) $display("[TB] FAIL after_ignore_digits: got %h expected %h", dg, refDigits(7, 1'b1)); else passCnt++;
    endtask

    task automatic test_random();
        int v, lat, bc;
        logic [11:0] dg;
        logic ov;
        for (int n = 0; n < 16; n++) begin
            v = int'($urandom_range(255, 0));
            startConv(0, v);
            waitDone(0, lat, bc, dg, ov);
            totalCnt++; if (dg !== refDigits(v, 1'b1)) $display("[TB] FAIL rand_digits v=%0d: got %h expected %h", v, dg, refDigits(v, 1'b1)); else passCnt++;
            totalCnt++; if (ov !== 1'b0) $display("[TB] FAIL rand_ovf v=%0d: got %b expected 0", v, ov); else passCnt++;
            totalCnt++; if (lat !== 9) $display("[TB] FAIL rand_latency v=%0d: got %0d expected 9", v, lat); else passCnt++;
            repeat ($urandom_range(2, 0)) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_no_blank();
        int v, lat, bc;
        logic [11:0] dg;
        logic ov;
        startConv(1, 5);
        waitDone(1, lat, bc, dg, ov);
        totalCnt++; if (dg !== 12'h005) $display("[TB] FAIL noblank_five: got %h expected 005", dg); else passCnt++;
        for (int n = 0; n < 6; n++) begin
            v = int'($urandom_range(255, 0));
            startConv(1, v);
            waitDone(1, lat, bc, dg, ov);
            totalCnt++; if (dg !== refDigits(v, 1'b0)) $display("[TB] FAIL noblank_rand v=%0d: got %h expected %h", v, dg, refDigits(v, 1'b0)); else passCnt++;
        end
    endtask

    task automatic test_overflow();
        int v, lat, bc;
        logic [11:0] dg;
        logic ov;
        startConv(2, 1023);
        waitDone(2, lat, bc, dg, ov);
        totalCnt++; if (dg !== 12'h999) $display("[TB] FAIL ovf_digits: got %h expected 999", dg); else passCnt++;
        totalCnt++; if (ov !== 1'b1) $display("[TB] FAIL ovf_flag: got %b expected 1", ov); else passCnt++;
        totalCnt++; if (lat !== 11) $display("[TB] FAIL wide_latency: got %0d expected 11", lat); else passCnt++;
        startConv(2, 999);
        waitDone(2, lat, bc, dg, ov);
        totalCnt++; if (dg !== 12'h999) $display("[TB] FAIL max_digits: got %h expected 999", dg); else passCnt++;
        totalCnt++; if (ov !== 1'b0) $display("[TB] FAIL ovf_clear: got %b expected 0", ov); else passCnt++;
        for (int n = 0; n < 8; n++) begin
            v = int'($urandom_range(1023, 0));
            startConv(2, v);
            waitDone(2, lat, bc, dg, ov);
            totalCnt++; if (dg !== refDigits(v, 1'b1)) $display("[TB] FAIL wide_rand v=%0d: got %h expected %h", v, dg, refDigits(v, 1'b1)); else passCnt++;
            totalCnt++; if (ov !== (v > 999)) $display("[TB] FAIL wide_ovf v=%0d: got %b expected %b", v, ov, (v > 999)); else passCnt++;
        end
    endtask

    task automatic test_reset_abort();
        int lat, bc;
        logic [11:0] dg;
        logic ov;
        bit sawDone;
        startConv(0, 123);
        waitDone(0, lat, bc, dg, ov);
        startConv(0, 200);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        totalCnt++; if (busyV[0] !== 1'b0) $display("[TB] FAIL abort_busy: got %b expected 0", busyV[0]); else passCnt++;
        totalCnt++; if (doneV[0] !== 1'b0) $display("[TB] FAIL abort_done: got %b expected 0", doneV[0]); else passCnt++;
        totalCnt++; if (digitsV[0] !== 12'hFF0) $display("[TB] FAIL abort_digits: got %h expected ff0", digitsV[0]); else passCnt++;
        totalCnt++; if (ovfV[0] !== 1'b0) $display("[TB] FAIL abort_ovf: got %b expected 0", ovfV[0]); else passCnt++;
        sawDone = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (doneV[0] === 1'b1) sawDone = 1'b1;
        end
        totalCnt++; if (sawDone !== 1'b0) $display("[TB] FAIL abort_no_done: got %b expected 0", sawDone); else passCnt++;
    endtask

    initial begin
        test_reset();
        test_zero();
        test_back_to_back();
        test_ignore_busy();
        test_random();
        test_no_blank();
        test_overflow();
        test_reset_abort();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
